// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer (start, DATA_BITS LSB first, optional parity, STOP_BITS stop).
// Latency: a write into an empty idle FIFO drives the start bit on the 2nd edge; queued bytes go out back-to-back.
// Backpressure: none; a write while full is dropped and sets sticky overflow. `UART_TX_BREAK_EN adds the brk line-break input.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_50mhz,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
`ifdef UART_TX_BREAK_EN
    input  logic                        brk,
`endif
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        TxD
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DIV);
    localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        BRK   = 3'd5
`endif
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic [7:0]      shift_n;
    logic [7:0]      head;
    logic            par_bit;
    logic            par_n;
    logic            txd_n;
    logic            push;
    logic            pop;
    logic            bit_tick;

    assign full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign push     = wr_en && !full;
    assign bit_tick = (baud_cnt == BW'(DIV - 1));
    // Unused upper payload bits are masked so parity and shifting see only DATA_BITS.
    assign head     = mem[rd_ptr] & DMASK;

    // Next state, FIFO pop request, and next serial-line level (TxD is registered to keep the line glitch-free).
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    state_n = BRK;
                end else
`endif
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_tick) state_n = DATA;
            end
            DATA: begin
                if (bit_tick && bit_cnt == 3'(DATA_BITS - 1))
                    state_n = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                if (bit_tick) state_n = STOP;
            end
            STOP: begin
                if (bit_tick && bit_cnt == 3'(STOP_BITS - 1)) begin
`ifdef UART_TX_BREAK_EN
                    if (brk) begin
                        state_n = BRK;
                    end else
`endif
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                if (!brk) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase

        shift_n = shift;
        par_n   = par_bit;
        if (pop) begin
            shift_n = head;
            par_n   = (^head) ^ (PARITY == 2);
        end else if (state == DATA && bit_tick) begin
            shift_n = shift >> 1;
        end

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            PAR:     txd_n = par_n;
`ifdef UART_TX_BREAK_EN
            BRK:     txd_n = 1'b0;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    // FSM, baud/bit counters, FIFO pointers and occupancy; reset aborts any frame and discards the queue.
    always_ff @(posedge clk_50mhz) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            TxD      <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            par_bit <= par_n;
            TxD     <= txd_n;
            // Every bit boundary coincides with a tick, so reloading on the tick keeps each bit exactly DIV cycles.
            baud_cnt <= (state == IDLE || bit_tick) ? '0 : baud_cnt + BW'(1);
            if (state_n != state)
                bit_cnt <= '0;
            else if (bit_tick)
                bit_cnt <= bit_cnt + 3'd1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW + 1)'(1);
            else if (!push && pop)
                count <= count - (AW + 1)'(1);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_50mhz) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk_50mhz frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line rate; DIV = CLK_HZ/BAUD, integer-truncated, and DIV ≥ 2.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning the number of queued bytes; power of 2, 2..256.
REQ-007 SHALL have port clk_50mhz, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous reset, active-low.
REQ-009 SHALL have port wr_en, input, 1 bit: write strobe, sampled each cycle.
REQ-010 SHALL have port wr_data, input, 8 bits: byte to queue; bits above DATA_BITS-1 ignored.
REQ-011 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-013 SHALL have port count, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port overflow, output, 1 bit: sticky; set by a write while full.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port TxD, output, 1 bit: serial line, idle high.

Function
REQ-017 SHALL accept a write when wr_en=1 and full=0; count rises by 1 at that edge.
REQ-018 SHALL drop a write when wr_en=1 and full=1, even if a pop occurs in the same cycle; overflow=1 from the next cycle.
REQ-019 SHALL, on a simultaneous accepted write and pop, keep count unchanged and preserve FIFO order.
REQ-020 SHALL wrap read and write pointers modulo FIFO_DEPTH; full/empty are derived from count only.
REQ-021 SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; the PARITY state is skipped when PARITY=0.
REQ-022 SHALL, in IDLE with empty=0, pop the head byte into the shift register and enter START at that edge.
REQ-023 SHALL drive TxD low on the 2nd rising edge after a write into an empty FIFO while IDLE.
REQ-024 SHALL hold each bit for exactly DIV cycles using a baud counter that reloads at each bit boundary.
REQ-025 SHALL send data LSB first, DATA_BITS bits, then the parity bit (even: XOR of the data bits; odd: its inverse), then STOP_BITS×DIV cycles high.
REQ-026 SHALL, when the FIFO is non-empty at the final STOP cycle, go directly to START with no idle gap (back-to-back frames).
REQ-027 SHALL make a frame last (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×DIV cycles.

Reset
REQ-028 SHALL, while rst=0 at a rising edge, set: TxD=1, busy=0, full=0, empty=1, count=0, overflow=0, FSM=IDLE, pointers=0, baud counter=0.
REQ-029 SHALL abort any frame in progress on reset; TxD is high from the first reset edge and queued data is discarded.

Configuration
REQ-030 SHALL, with macro UART_TX_BREAK_EN defined, add input brk (1 bit): brk=1 while IDLE forces TxD=0 and busy=1, with no FIFO pops.
REQ-031 SHALL, with UART_TX_BREAK_EN defined, defer a brk asserted mid-frame until that frame's stop bits complete; pops resume the cycle after brk=0.
REQ-032 SHALL, without UART_TX_BREAK_EN, omit the brk port and all break logic.

Verification (CLK_HZ=50000000, BAUD=5000000, so DIV=10)
REQ-033 SHALL cover: reset, then write 0x55 with 8N1 -> TxD low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles; busy high for 100 cycles.
REQ-034 SHALL cover: PARITY=2, DATA_BITS=7, write 0x41 -> data bits 1000001, then parity bit 1; frame is 100 cycles.
REQ-035 SHALL cover: FIFO_DEPTH=4, write 6 bytes on consecutive cycles -> first byte popped, 4 queued, full=1, 1 byte dropped, overflow=1; 5 frames sent back-to-back.
REQ-036 SHALL cover: rst=0 asserted 35 cycles into a frame -> TxD=1 and count=0 on the next edge; a fresh write afterwards transmits correctly.
REQ-037 SHALL cover: with UART_TX_BREAK_EN, brk=1 raised mid-frame -> frame completes, then TxD=0 while brk=1; queued byte sent after brk=0.
REQ-038 SHALL cover: STOP_BITS=2, two bytes written -> 20 high cycles between frames, and the second start bit follows with no extra gap.
